// File: rtl/fwd_ctrl.sv
// Forwarding / load-use stall controller for the 6-stage MIPS pipeline (ID -> EX operand selects).
// Optional build macro FWD_STATS_EN adds saturating stall_cycles / fwd_events counters.
module fwd_ctrl #(
    parameter int REG_AW     = 5,
    parameter int LOAD_STALL = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_wr_en,
    input  logic              id_is_load,
    input  logic              flush,
    output logic              stall,
    output logic              ex_valid,
    output logic [1:0]        sel_a,
    output logic [1:0]        sel_b
`ifdef FWD_STATS_EN
    ,
    output logic [31:0]       stall_cycles,
    output logic [31:0]       fwd_events
`endif
);

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              wr_en;
        logic              is_load;
    } ex_slot_t;

    // MEM forwarding never cares whether the producer was a load.
    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              wr_en;
    } mem_slot_t;

    ex_slot_t  ex_q, ex_d;
    mem_slot_t mem_q;
    logic [1:0] cnt_q, cnt_d;
    logic [1:0] sel_a_d, sel_b_d;
    logic hit_ex_a, hit_ex_b, hit_mem_a, hit_mem_b;
    logic load_use, adv;

    function automatic logic src_hit(input logic use_src, input logic vld, input logic wr,
                                     input logic [REG_AW-1:0] rd, input logic [REG_AW-1:0] src);
        return use_src & vld & wr & (rd == src) & (src != '0);
    endfunction

    function automatic logic [1:0] pick(input logic h_ex, input logic ex_ld, input logic h_mem);
        if (h_ex && !ex_ld) return 2'd1;
        else if (h_mem)     return 2'd2;
        else                return 2'd0;
    endfunction

    always_comb begin
        hit_ex_a  = src_hit(id_use_rs, ex_q.valid, ex_q.wr_en, ex_q.rd, id_rs);
        hit_ex_b  = src_hit(id_use_rt, ex_q.valid, ex_q.wr_en, ex_q.rd, id_rt);
        hit_mem_a = src_hit(id_use_rs, mem_q.valid, mem_q.wr_en, mem_q.rd, id_rs);
        hit_mem_b = src_hit(id_use_rt, mem_q.valid, mem_q.wr_en, mem_q.rd, id_rt);
        load_use  = id_valid & ex_q.is_load & (hit_ex_a | hit_ex_b);
        stall     = (cnt_q != 2'd0) | ((cnt_q == 2'd0) & load_use);
        adv       = id_valid & ~stall & ~flush;

        ex_d    = '0;
        sel_a_d = 2'd0;
        sel_b_d = 2'd0;
        if (adv) begin
            ex_d    = '{valid: 1'b1, rd: id_rd, wr_en: id_wr_en, is_load: id_is_load};
            sel_a_d = pick(hit_ex_a, ex_q.is_load, hit_mem_a);
            sel_b_d = pick(hit_ex_b, ex_q.is_load, hit_mem_b);
        end

        cnt_d = cnt_q;
        if (flush)                 cnt_d = 2'd0;
        else if (cnt_q != 2'd0)    cnt_d = cnt_q - 2'd1;
        else if (load_use)         cnt_d = 2'(LOAD_STALL - 1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q     <= '0;
            mem_q    <= '0;
            cnt_q    <= 2'd0;
            ex_valid <= 1'b0;
            sel_a    <= 2'd0;
            sel_b    <= 2'd0;
        end else begin
            ex_q     <= ex_d;
            mem_q    <= '{valid: ex_q.valid, rd: ex_q.rd, wr_en: ex_q.wr_en};
            cnt_q    <= cnt_d;
            ex_valid <= adv;
            sel_a    <= sel_a_d;
            sel_b    <= sel_b_d;
        end
    end

`ifdef FWD_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            fwd_events   <= '0;
        end else begin
            if (stall && stall_cycles != '1)
                stall_cycles <= stall_cycles + 32'd1;
            if ((sel_a_d != 2'd0 || sel_b_d != 2'd0) && fwd_events != '1)
                fwd_events <= fwd_events + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fwd_ctrl.sv
// Scoreboard bench for fwd_ctrl: two instances (LOAD_STALL=1 and 2) share one directed ID stream.
module tb_fwd_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       id_valid, id_use_rs, id_use_rt, id_wr_en, id_is_load, flush;
    logic [4:0] id_rs, id_rt, id_rd;
    logic       stall1, ev1, stall2, ev2;
    logic [1:0] sa1, sb1, sa2, sb2;
`ifdef FWD_STATS_EN
    logic [31:0] sc1, fe1, sc2, fe2;
`endif

    fwd_ctrl #(.REG_AW(5), .LOAD_STALL(1)) u1 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rd(id_rd), .id_wr_en(id_wr_en),
        .id_is_load(id_is_load), .flush(flush), .stall(stall1), .ex_valid(ev1),
        .sel_a(sa1), .sel_b(sb1)
`ifdef FWD_STATS_EN
        , .stall_cycles(sc1), .fwd_events(fe1)
`endif
    );

    fwd_ctrl #(.REG_AW(5), .LOAD_STALL(2)) u2 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rd(id_rd), .id_wr_en(id_wr_en),
        .id_is_load(id_is_load), .flush(flush), .stall(stall2), .ex_valid(ev2),
        .sel_a(sa2), .sel_b(sb2)
`ifdef FWD_STATS_EN
        , .stall_cycles(sc2), .fwd_events(fe2)
`endif
    );

    typedef struct packed {
        logic       v;
        logic [4:0] rs, rt;
        logic       urs, urt;
        logic [4:0] rd;
        logic       wr, ld, fl;
    } vec_t;

    // Expected observations during the cycle a row's inputs are presented.
    typedef struct packed {
        logic       s1, s2, e1;
        logic [1:0] a1, b1;
        logic       e2;
        logic [1:0] a2, b2;
    } exp_t;

    vec_t vq[$];
    exp_t tq[$];
    exp_t sbq[$];
    int checks = 0;
    int errors = 0;
    int mon_n  = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic r(input int v, input int rs, input int rt, input int urs, input int urt,
                     input int rd, input int wr, input int ld, input int fl,
                     input int s1, input int s2, input int e1, input int a1, input int b1,
                     input int e2, input int a2, input int b2);
        vec_t vv;
        exp_t ee;
        vv.v = 1'(v); vv.rs = 5'(rs); vv.rt = 5'(rt); vv.urs = 1'(urs); vv.urt = 1'(urt);
        vv.rd = 5'(rd); vv.wr = 1'(wr); vv.ld = 1'(ld); vv.fl = 1'(fl);
        ee.s1 = 1'(s1); ee.s2 = 1'(s2); ee.e1 = 1'(e1); ee.a1 = 2'(a1); ee.b1 = 2'(b1);
        ee.e2 = 1'(e2); ee.a2 = 2'(a2); ee.b2 = 2'(b2);
        vq.push_back(vv);
        tq.push_back(ee);
    endtask

    task automatic apply(input vec_t vv);
        id_valid = vv.v; id_rs = vv.rs; id_rt = vv.rt; id_use_rs = vv.urs; id_use_rt = vv.urt;
        id_rd = vv.rd; id_wr_en = vv.wr; id_is_load = vv.ld; flush = vv.fl;
    endtask

    // Monitor: one expected entry per presented cycle.
    initial begin
        forever begin
            exp_t e;
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk($sformatf("r%0d stall1", mon_n), int'(stall1), int'(e.s1));
                chk($sformatf("r%0d stall2", mon_n), int'(stall2), int'(e.s2));
                chk($sformatf("r%0d ex_valid1", mon_n), int'(ev1), int'(e.e1));
                chk($sformatf("r%0d sel_a1", mon_n), int'(sa1), int'(e.a1));
                chk($sformatf("r%0d sel_b1", mon_n), int'(sb1), int'(e.b1));
                chk($sformatf("r%0d ex_valid2", mon_n), int'(ev2), int'(e.e2));
                chk($sformatf("r%0d sel_a2", mon_n), int'(sa2), int'(e.a2));
                chk($sformatf("r%0d sel_b2", mon_n), int'(sb2), int'(e.b2));
                mon_n++;
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        apply('0);
        //  v rs rt us ut rd wr ld fl | s1 s2 | e1 a1 b1 | e2 a2 b2
        r(1, 1, 2, 1, 1, 3, 1, 0, 0,   0, 0,   0, 0, 0,   0, 0, 0);  // 0 add r3
        r(1, 3, 2, 1, 1, 4, 1, 0, 0,   0, 0,   1, 0, 0,   1, 0, 0);  // 1 sub r4 <- r3
        r(1, 1, 1, 1, 1, 5, 1, 0, 0,   0, 0,   1, 1, 0,   1, 1, 0);  // 2 write r5
        r(1, 6, 6, 1, 1, 5, 1, 0, 0,   0, 0,   1, 0, 0,   1, 0, 0);  // 3 write r5 again
        r(1, 1, 5, 1, 1, 8, 1, 0, 0,   0, 0,   1, 0, 0,   1, 0, 0);  // 4 read r5 on rt
        r(1, 1, 1, 1, 1, 9, 1, 0, 0,   0, 0,   1, 0, 1,   1, 0, 1);  // 5 write r9
        r(0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0,   1, 0, 0,   1, 0, 0);  // 6 nop
        r(1, 1, 9, 1, 1, 10, 1, 0, 0,  0, 0,   0, 0, 0,   0, 0, 0);  // 7 read r9 at distance 2
        r(1, 1, 0, 1, 0, 7, 1, 1, 0,   0, 0,   1, 0, 2,   1, 0, 2);  // 8 lw r7
        r(1, 7, 2, 1, 1, 11, 1, 0, 0,  1, 1,   1, 0, 0,   1, 0, 0);  // 9 add <- r7 (hazard)
        r(1, 7, 2, 1, 1, 11, 1, 0, 0,  0, 1,   0, 0, 0,   0, 0, 0);  // 10 held
        r(1, 7, 2, 1, 1, 11, 1, 0, 0,  0, 0,   1, 2, 0,   0, 0, 0);  // 11 held
        r(0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0,   1, 0, 0,   1, 0, 0);  // 12 nop
        r(1, 1, 0, 1, 0, 0, 1, 1, 0,   0, 0,   0, 0, 0,   0, 0, 0);  // 13 lw r0
        r(1, 0, 0, 1, 1, 12, 1, 0, 0,  0, 0,   1, 0, 0,   1, 0, 0);  // 14 add <- r0,r0
        r(1, 0, 0, 1, 1, 13, 1, 0, 0,  0, 0,   1, 0, 0,   1, 0, 0);  // 15 add <- r0,r0
        r(1, 1, 0, 1, 0, 4, 1, 1, 0,   0, 0,   1, 0, 0,   1, 0, 0);  // 16 lw r4
        r(1, 4, 2, 1, 1, 14, 1, 0, 1,  1, 1,   1, 0, 0,   1, 0, 0);  // 17 add <- r4, flush
        r(1, 1, 2, 1, 1, 15, 1, 0, 0,  0, 0,   0, 0, 0,   0, 0, 0);  // 18 add r15
        r(1, 4, 15, 1, 1, 16, 1, 0, 0, 0, 0,   1, 0, 0,   1, 0, 0);  // 19 add <- r4,r15
        r(0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0,   1, 0, 1,   1, 0, 1);  // 20 nop
        r(1, 1, 0, 1, 0, 20, 1, 1, 0,  0, 0,   0, 0, 0,   0, 0, 0);  // 21 lw r20
        r(1, 20, 20, 1, 1, 21, 1, 0, 0, 1, 1,  1, 0, 0,   1, 0, 0);  // 22 add <- r20,r20
        r(1, 20, 20, 1, 1, 21, 1, 0, 0, 0, 1,  0, 0, 0,   0, 0, 0);  // 23 held
        r(1, 20, 20, 1, 1, 21, 1, 0, 0, 0, 0,  1, 2, 2,   0, 0, 0);  // 24 held
        r(0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0,   1, 0, 0,   1, 0, 0);  // 25 nop
        r(1, 1, 0, 1, 0, 4, 1, 1, 0,   0, 0,   0, 0, 0,   0, 0, 0);  // 26 lw r4
        r(1, 4, 2, 1, 1, 5, 1, 0, 0,   1, 1,   1, 0, 0,   1, 0, 0);  // 27 add <- r4
        r(1, 4, 2, 1, 1, 5, 1, 0, 0,   0, 1,   0, 0, 0,   0, 0, 0);  // 28 held, reset mid-stall
        r(0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0,   1, 0, 0,   1, 0, 0);  // 29 nop
        r(0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0,   0, 0, 0,   0, 0, 0);  // 30 nop

        #12;
        chk("reset stall1", int'(stall1), 0);
        chk("reset ex_valid1", int'(ev1), 0);
        chk("reset sel_a1", int'(sa1), 0);
        chk("reset sel_b1", int'(sb1), 0);
        chk("reset stall2", int'(stall2), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            @(posedge clk);
            #1;
            apply(vq[i]);
            sbq.push_back(tq[i]);
`ifdef FWD_STATS_EN
            if (i == 26) begin
                chk("stall_cycles1", int'(sc1), 3);
                chk("fwd_events1", int'(fe1), 6);
                chk("stall_cycles2", int'(sc2), 5);
                chk("fwd_events2", int'(fe2), 4);
            end
`endif
            if (i == 28) begin
                @(negedge clk);
                #1 rst_n = 1'b0;
                #1;
                chk("midrst stall2", int'(stall2), 0);
                chk("midrst stall1", int'(stall1), 0);
                chk("midrst ex_valid2", int'(ev2), 0);
                chk("midrst sel_a2", int'(sa2), 0);
`ifdef FWD_STATS_EN
                chk("midrst stall_cycles2", int'(sc2), 0);
                chk("midrst fwd_events1", int'(fe1), 0);
`endif
                #1 rst_n = 1'b1;
            end
        end

        @(posedge clk);
        repeat (2) @(negedge clk);
        #1;
        chk("scoreboard drained", sbq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
